mor1kx_shadow_stack_monitor: RTL and testbench

//  Hardware return-address checker downstream of the GPR file write port.
//  - Snoops link-register (r9) writes made by l.jal/l.jalr commits and pushes them onto a private LIFO.
//  - On each committed l.jr through r9, pops the LIFO and compares the entry with the jump target.
//  - Flags mismatch, underflow or overflow to the debug/exception unit.

---
 rtl/mor1kx_shstk_pkg.sv | 20 ++
 rtl/mor1kx_shstk_lifo.sv | 56 +++++
 rtl/mor1kx_shadow_stack_monitor.sv | 128 ++++++++++++
 tb/tb_mor1kx_shadow_stack_monitor.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_shstk_pkg.sv
// Shared definitions for the mor1kx shadow-stack return-address monitor.
//   LR_ADDR             : GPR index of the link register (r9)
//   shstk_state_t       : monitor FSM states (RUN / FAULT)
//   CAUSE_*             : bit positions of the fault-cause vector
//                         {overflow, underflow, mismatch}
package mor1kx_shstk_pkg;

  localparam logic [4:0] LR_ADDR = 5'd9;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } shstk_state_t;

  localparam int CAUSE_MISMATCH  = 0;
  localparam int CAUSE_UNDERFLOW = 1;
  localparam int CAUSE_OVERFLOW  = 2;
  localparam int CAUSE_W         = 3;

endpackage

// File: rtl/mor1kx_shstk_lifo.sv
// Circular LIFO holding return addresses for the shadow-stack monitor.
// When full, a push overwrites the oldest entry; the count saturates at DEPTH.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer/count only)
//   push       : write wdata at ptr, ptr++, count = min(count+1, DEPTH)
//   pop        : ptr--, count-- (caller guarantees count != 0)
//   swap       : overwrite the top slot with wdata, ptr/count unchanged
//   wdata      : value for push/swap
//   top        : entry at ptr-1 (valid only when count != 0)
//   count      : current number of live entries
// The caller keeps push, pop and swap mutually exclusive.
module mor1kx_shstk_lifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       swap,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end

  // Storage has no reset: entries are never read while count is zero.
  always_ff @(posedge clk) begin
    if (push)      mem[ptr]     <= wdata;
    else if (swap) mem[top_idx] <= wdata;
  end

endmodule

// File: rtl/mor1kx_shadow_stack_monitor.sv
// Shadow-stack monitor: snoops r9 writes by l.jal/l.jalr and checks each
// committed l.jr r9 target against the saved return address.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   rf_we_i/rf_waddr_i/rf_wdata_i : GPR write-back port
//   call_i         : write-back belongs to l.jal/l.jalr
//   ret_i          : l.jr r9 commits this cycle, target on ret_target_i
//   clear_i        : synchronous clear of sticky flags, FAULT -> RUN
//   depth_o        : live entry count
//   mismatch_o/underflow_o/overflow_o : sticky fault flags
//   violation_o    : one-cycle pulse on every new fault
//   trap_o, halt_o : only with MOR1KX_SHSTK_TRAP_EN defined; trap_o while the
//                    FSM is in FAULT, halt_o while any sticky flag is set.
// Flags and violation_o are registered: a fault in cycle N shows at N+1.
module mor1kx_shadow_stack_monitor
  import mor1kx_shstk_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int SHSTK_DEPTH          = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rf_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rf_waddr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_wdata_i,
  input  logic                            call_i,
  input  logic                            ret_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ret_target_i,
  input  logic                            clear_i,
  output logic [$clog2(SHSTK_DEPTH):0]    depth_o,
  output logic                            mismatch_o,
  output logic                            underflow_o,
  output logic                            overflow_o,
  output logic                            violation_o
`ifdef MOR1KX_SHSTK_TRAP_EN
  ,
  output logic                            trap_o,
  output logic                            halt_o
`endif
);

  localparam int CW = $clog2(SHSTK_DEPTH) + 1;

  logic                            push;
  logic                            nonempty;
  logic                            full;
  logic                            lifo_push;
  logic                            lifo_pop;
  logic                            lifo_swap;
  logic [OPTION_OPERAND_WIDTH-1:0] top;
  logic [CW-1:0]                   count;
  logic [CAUSE_W-1:0]              cause;
  logic [CAUSE_W-1:0]              flags;
  logic                            violation;
  shstk_state_t                    state;
  shstk_state_t                    state_next;

  assign push     = rf_we_i & call_i &
                    (rf_waddr_i == OPTION_RF_ADDR_WIDTH'(LR_ADDR));
  assign nonempty = (count != '0);
  assign full     = (count == CW'(SHSTK_DEPTH));

  // A return on an empty stack does nothing to the LIFO, so a same-cycle call
  // is then an ordinary push. Otherwise push+pop becomes a swap of the top.
  assign lifo_swap = push & ret_i & nonempty;
  assign lifo_push = push & ~lifo_swap;
  assign lifo_pop  = ret_i & nonempty & ~push;

  mor1kx_shstk_lifo #(
    .WIDTH (OPTION_OPERAND_WIDTH),
    .DEPTH (SHSTK_DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lifo_push),
    .pop   (lifo_pop),
    .swap  (lifo_swap),
    .wdata (rf_wdata_i),
    .top   (top),
    .count (count)
  );

  // Compare against the pre-push top; overflow only when the stack really
  // grows past full (a swap keeps the count).
  always_comb begin
    cause = '0;
    if (ret_i) begin
      if (!nonempty)              cause[CAUSE_UNDERFLOW] = 1'b1;
      else if (top != ret_target_i) cause[CAUSE_MISMATCH] = 1'b1;
    end
    if (push && !ret_i && full)   cause[CAUSE_OVERFLOW]  = 1'b1;
  end

  // New faults win over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags     <= '0;
      violation <= 1'b0;
      state     <= ST_RUN;
    end else begin
      flags     <= clear_i ? cause : (flags | cause);
      violation <= |cause;
      state     <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (|cause)                state_next = ST_FAULT;
      ST_FAULT: if (clear_i && !(|cause))  state_next = ST_RUN;
      default:                             state_next = ST_RUN;
    endcase
  end

  assign depth_o     = count;
  assign mismatch_o  = flags[CAUSE_MISMATCH];
  assign underflow_o = flags[CAUSE_UNDERFLOW];
  assign overflow_o  = flags[CAUSE_OVERFLOW];
  assign violation_o = violation;

`ifdef MOR1KX_SHSTK_TRAP_EN
  assign trap_o = (state == ST_FAULT);
  assign halt_o = |flags;
`endif

endmodule

// File: tb/tb_mor1kx_shadow_stack_monitor.sv
// Self-checking bench for mor1kx_shadow_stack_monitor (optional
// MOR1KX_SHSTK_TRAP_EN adds trap_o/halt_o checks). The reference model is a
// bounded queue of return addresses plus sticky flag bits.
module tb_mor1kx_shadow_stack_monitor;

  localparam int DEPTH = 16;
  localparam int DW    = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we_i = 1'b0;
  logic [4:0]  rf_waddr_i = '0;
  logic [31:0] rf_wdata_i = '0;
  logic        call_i = 1'b0;
  logic        ret_i = 1'b0;
  logic [31:0] ret_target_i = '0;
  logic        clear_i = 1'b0;
  logic [DW-1:0] depth_o;
  logic        mismatch_o, underflow_o, overflow_o, violation_o;
`ifdef MOR1KX_SHSTK_TRAP_EN
  logic        trap_o, halt_o;
`endif

  mor1kx_shadow_stack_monitor #(
    .OPTION_OPERAND_WIDTH (32),
    .OPTION_RF_ADDR_WIDTH (5),
    .SHSTK_DEPTH          (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rf_we_i      (rf_we_i),
    .rf_waddr_i   (rf_waddr_i),
    .rf_wdata_i   (rf_wdata_i),
    .call_i       (call_i),
    .ret_i        (ret_i),
    .ret_target_i (ret_target_i),
    .clear_i      (clear_i),
    .depth_o      (depth_o),
    .mismatch_o   (mismatch_o),
    .underflow_o  (underflow_o),
    .overflow_o   (overflow_o),
    .violation_o  (violation_o)
`ifdef MOR1KX_SHSTK_TRAP_EN
    ,
    .trap_o       (trap_o),
    .halt_o       (halt_o)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];        // oldest at front, top at back
  logic [2:0]  exp_flags;       // {overflow, underflow, mismatch}
  logic        exp_viol;
  logic        exp_fault_st;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [DW-1:0] exp_depth();
    return DW'(exp_q.size());
  endfunction

  // Apply one cycle of inputs (called at a negedge), update the model at the
  // active edge, return at the next negedge with inputs idle.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic call, input logic ret, input logic [31:0] tgt,
                       input logic clr);
    logic [2:0]  f;
    logic [31:0] t;
    rf_we_i = we; rf_waddr_i = wa; rf_wdata_i = wd; call_i = call;
    ret_i = ret; ret_target_i = tgt; clear_i = clr;
    @(posedge clk);
    f = '0;
    if (ret) begin
      if (exp_q.size() == 0) f[1] = 1'b1;
      else begin
        t = exp_q.pop_back();
        if (t !== tgt) f[0] = 1'b1;
      end
    end
    if (we && call && wa == 5'd9) begin
      if (!ret && exp_q.size() == DEPTH) begin
        f[2] = 1'b1;
        void'(exp_q.pop_front());
      end
      exp_q.push_back(wd);
    end
    exp_flags    = clr ? f : (exp_flags | f);
    exp_viol     = |f;
    exp_fault_st = (|f) ? 1'b1 : (clr ? 1'b0 : exp_fault_st);
    @(negedge clk);
    rf_we_i = 1'b0; rf_waddr_i = '0; rf_wdata_i = '0; call_i = 1'b0;
    ret_i = 1'b0; ret_target_i = '0; clear_i = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] a);
    cycle(1'b1, 5'd9, a, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic do_ret(input logic [31:0] a);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, a, 1'b0);
  endtask
  task automatic do_idle();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic do_clear();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_flags = '0; exp_viol = 1'b0; exp_fault_st = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++;
    if ({depth_o, overflow_o, underflow_o, mismatch_o, violation_o} !== {DW'(0), 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_state: got depth=%0d flags=%b viol=%b, want all zero",
               depth_o, {overflow_o, underflow_o, mismatch_o}, violation_o);
    end
`ifdef MOR1KX_SHSTK_TRAP_EN
    vectors++;
    if ({trap_o, halt_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_trap: got trap=%b halt=%b, want 0 0", trap_o, halt_o);
    end
`endif
  endtask

  task automatic test_balanced();
    do_reset();
    do_push(32'h100);
    do_push(32'h200);
    vectors++;
    if (depth_o !== DW'(2)) begin
      miscompares++; $display("FAIL balanced_depth2: got %0d want 2", depth_o);
    end
    do_ret(32'h200);
    vectors++;
    if (violation_o !== 1'b0 || depth_o !== DW'(1)) begin
      miscompares++; $display("FAIL balanced_ret1: got viol=%b depth=%0d want 0 1", violation_o, depth_o);
    end
    do_ret(32'h100);
    vectors++;
    if ({depth_o, overflow_o, underflow_o, mismatch_o, violation_o} !== {DW'(0), 4'b0000}) begin
      miscompares++;
      $display("FAIL balanced_end: got depth=%0d flags=%b viol=%b want 0 000 0",
               depth_o, {overflow_o, underflow_o, mismatch_o}, violation_o);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    do_push(32'h100);
    do_ret(32'h104);
    vectors++;
    if ({mismatch_o, underflow_o, overflow_o, violation_o, depth_o} !== {4'b1001, DW'(0)}) begin
      miscompares++;
      $display("FAIL mismatch_flag: got mis=%b und=%b ovf=%b viol=%b depth=%0d want 1 0 0 1 0",
               mismatch_o, underflow_o, overflow_o, violation_o, depth_o);
    end
    do_idle();
    vectors++;
    if (violation_o !== 1'b0 || mismatch_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mismatch_pulse: got viol=%b mis=%b want 0 1", violation_o, mismatch_o);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    do_ret(32'h0);
    vectors++;
    if ({underflow_o, mismatch_o, violation_o, depth_o} !== {3'b101, DW'(0)}) begin
      miscompares++;
      $display("FAIL underflow_flag: got und=%b mis=%b viol=%b depth=%0d want 1 0 1 0",
               underflow_o, mismatch_o, violation_o, depth_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= 16; i++) do_push(32'h1000 + 32'(4 * i));
    vectors++;
    if (overflow_o !== 1'b1 || depth_o !== DW'(16)) begin
      miscompares++; $display("FAIL overflow_full: got ovf=%b depth=%0d want 1 16", overflow_o, depth_o);
    end
    for (int i = 16; i >= 1; i--) begin
      do_ret(32'h1000 + 32'(4 * i));
      vectors++;
      if (violation_o !== 1'b0 || mismatch_o !== 1'b0 || depth_o !== exp_depth()) begin
        miscompares++;
        $display("FAIL overflow_ret%0d: got viol=%b mis=%b depth=%0d want 0 0 %0d",
                 i, violation_o, mismatch_o, depth_o, exp_depth());
      end
    end
    do_ret(32'h1000);
    vectors++;
    if ({underflow_o, mismatch_o, violation_o} !== 3'b101 || depth_o !== DW'(0)) begin
      miscompares++;
      $display("FAIL overflow_17th_ret: got und=%b mis=%b viol=%b depth=%0d want 1 0 1 0",
               underflow_o, mismatch_o, violation_o, depth_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_push(32'hA0);
    cycle(1'b1, 5'd9, 32'hB0, 1'b1, 1'b1, 32'hA0, 1'b0);
    vectors++;
    if (violation_o !== 1'b0 || depth_o !== DW'(1)) begin
      miscompares++; $display("FAIL swap_cycle: got viol=%b depth=%0d want 0 1", violation_o, depth_o);
    end
    do_ret(32'hB0);
    vectors++;
    if ({mismatch_o, underflow_o, violation_o, depth_o} !== {3'b000, DW'(0)}) begin
      miscompares++;
      $display("FAIL swap_next_ret: got mis=%b und=%b viol=%b depth=%0d want 0 0 0 0",
               mismatch_o, underflow_o, violation_o, depth_o);
    end
  endtask

  task automatic test_clear();
    do_reset();
    do_ret(32'h4);
`ifdef MOR1KX_SHSTK_TRAP_EN
    vectors++;
    if ({trap_o, halt_o} !== 2'b11) begin
      miscompares++; $display("FAIL trap_set: got trap=%b halt=%b want 1 1", trap_o, halt_o);
    end
    do_idle();
    vectors++;
    if ({trap_o, halt_o} !== 2'b11) begin
      miscompares++; $display("FAIL trap_hold: got trap=%b halt=%b want 1 1", trap_o, halt_o);
    end
`endif
    do_clear();
    vectors++;
    if ({overflow_o, underflow_o, mismatch_o, violation_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL clear_flags: got flags=%b viol=%b want 000 0",
               {overflow_o, underflow_o, mismatch_o}, violation_o);
    end
`ifdef MOR1KX_SHSTK_TRAP_EN
    vectors++;
    if ({trap_o, halt_o} !== 2'b00) begin
      miscompares++; $display("FAIL trap_clear: got trap=%b halt=%b want 0 0", trap_o, halt_o);
    end
`endif
    // Fault arriving with clear keeps its flag.
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b1);
    vectors++;
    if ({underflow_o, violation_o} !== 2'b11) begin
      miscompares++; $display("FAIL clear_vs_fault: got und=%b viol=%b want 1 1", underflow_o, violation_o);
    end
  endtask

  task automatic test_no_push();
    do_reset();
    cycle(1'b1, 5'd9, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 5'd3, 32'h304, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 5'd9, 32'h308, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (depth_o !== DW'(0)) begin
      miscompares++; $display("FAIL no_push_depth: got %0d want 0", depth_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_push(32'h40); do_push(32'h44); do_push(32'h48);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (depth_o !== DW'(0)) begin
      miscompares++; $display("FAIL async_reset_depth: got %0d want 0", depth_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_flags = '0; exp_viol = 1'b0; exp_fault_st = 1'b0;
  endtask

  task automatic test_random();
    int          r;
    logic [31:0] tgt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r   = $urandom_range(0, 19);
      tgt = (exp_q.size() != 0 && $urandom_range(0, 5) != 0) ? exp_q[$] : $urandom();
      if (r < 8)       do_push($urandom());
      else if (r < 14) do_ret(tgt);
      else if (r < 16) cycle(1'b1, 5'd9, $urandom(), 1'b1, 1'b1, tgt, 1'b0);
      else if (r < 18) cycle(1'b1, 5'($urandom_range(0, 31)), $urandom(),
                             1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
      else if (r < 19) do_clear();
      else             do_idle();
      vectors++;
      if (depth_o !== exp_depth() || {overflow_o, underflow_o, mismatch_o} !== exp_flags
          || violation_o !== exp_viol) begin
        miscompares++;
        $display("FAIL random_%0d: got depth=%0d flags=%b viol=%b want depth=%0d flags=%b viol=%b",
                 n, depth_o, {overflow_o, underflow_o, mismatch_o}, violation_o,
                 exp_depth(), exp_flags, exp_viol);
      end
`ifdef MOR1KX_SHSTK_TRAP_EN
      vectors++;
      if (trap_o !== exp_fault_st || halt_o !== (|exp_flags)) begin
        miscompares++;
        $display("FAIL random_trap_%0d: got trap=%b halt=%b want %b %b",
                 n, trap_o, halt_o, exp_fault_st, |exp_flags);
      end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    exp_flags = '0; exp_viol = 1'b0; exp_fault_st = 1'b0;
    test_reset();
    test_balanced();
    test_mismatch();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_no_push();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
